// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port active-low SRAM macro.
// Supports locked bursts with a starvation cap and returns read data tagged to the issuing port.
module sram_rr_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          sram_scn,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic [1:0]    dbg_lock_state
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_state_e;

  lock_state_e       lock_state;
  logic [HW-1:0]     hold_cnt;
  logic              last_gnt;
  logic              cap_hit;
  logic              grant_p0;
  logic              grant_p1;
  logic              rd_issue;
  logic              gnt_lock;
  logic              same_owner;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_port;

  // Handshake: reqP with stable command fields is held until gntP is seen high;
  // the command is taken at the rising edge that ends the cycle in which gntP=1.
  always_comb begin
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    cap_hit  = (hold_cnt >= HW'(MAX_HOLD));
    if (hrst) begin
      grant_p0 = 1'b0;
    end else if (lock_state == LOCK_P0 && req0 && !(req1 && cap_hit)) begin
      grant_p0 = 1'b1;
    end else if (lock_state == LOCK_P1 && req1 && !(req0 && cap_hit)) begin
      grant_p1 = 1'b1;
    end else if (req0 && req1) begin
      grant_p0 = last_gnt;
      grant_p1 = ~last_gnt;
    end else if (req0) begin
      grant_p0 = 1'b1;
    end else if (req1) begin
      grant_p1 = 1'b1;
    end
  end

  assign gnt0           = grant_p0;
  assign gnt1           = grant_p1;
  assign rd_issue       = (grant_p0 & ~we0) | (grant_p1 & ~we1);
  assign gnt_lock       = grant_p0 ? lock0 : lock1;
  assign same_owner     = (grant_p0 && lock_state == LOCK_P0) || (grant_p1 && lock_state == LOCK_P1);
  assign dbg_lock_state = lock_state;

  always_comb begin
    sram_scn = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (grant_p0) begin
      sram_scn = 1'b0;
      sram_wen = ~we0;
      sram_a   = addr0;
      sram_d   = wdata0;
    end else if (grant_p1) begin
      sram_scn = 1'b0;
      sram_wen = ~we1;
      sram_a   = addr1;
      sram_d   = wdata1;
    end
  end

  // A beat that changes owner restarts the count, so a capped port cannot
  // inherit the previous owner's hold budget.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      last_gnt   <= 1'b1;
      lock_state <= LOCK_NONE;
      hold_cnt   <= '0;
    end else if (grant_p0 || grant_p1) begin
      last_gnt <= grant_p1;
      if (gnt_lock) begin
        lock_state <= grant_p0 ? LOCK_P0 : LOCK_P1;
        if (!same_owner) begin
          hold_cnt <= HW'(1);
        end else if (hold_cnt != {HW{1'b1}}) begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end else begin
        lock_state <= LOCK_NONE;
        hold_cnt   <= '0;
      end
    end else begin
      lock_state <= LOCK_NONE;
      hold_cnt   <= '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      pipe_vld  <= '0;
      pipe_port <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      pipe_vld[0]  <= rd_issue;
      pipe_port[0] <= grant_p1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_port[i] <= pipe_port[i-1];
      end
      rvalid0 <= pipe_vld[RD_LAT-1] & ~pipe_port[RD_LAT-1];
      rvalid1 <= pipe_vld[RD_LAT-1] & pipe_port[RD_LAT-1];
      if (pipe_vld[RD_LAT-1] && !pipe_port[RD_LAT-1]) begin
        rdata0 <= sram_q;
      end
      if (pipe_vld[RD_LAT-1] && pipe_port[RD_LAT-1]) begin
        rdata1 <= sram_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: two instances (RD_LAT 1 and 2) share directed stimulus,
// each with its own SRAM model and read-return scoreboard.
module tb_sram_rr_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
  localparam int MAX_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic hrst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, scn_a, wen_a;
  logic [DW-1:0] rdata0_a, rdata1_a, d_a, q_a;
  logic [AW-1:0] a_a;
  logic [1:0] st_a;
  logic gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, scn_b, wen_b;
  logic [DW-1:0] rdata0_b, rdata1_b, d_b, q_b;
  logic [AW-1:0] a_b;
  logic [1:0] st_b;

  sram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_A), .MAX_HOLD(MAX_HOLD)) dut_a (
    .hclk(clk), .hrst(hrst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0_a), .gnt1(gnt1_a),
    .rvalid0(rvalid0_a), .rvalid1(rvalid1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .sram_scn(scn_a), .sram_wen(wen_a), .sram_a(a_a), .sram_d(d_a), .sram_q(q_a),
    .dbg_lock_state(st_a)
  );

  sram_rr_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT_B), .MAX_HOLD(MAX_HOLD)) dut_b (
    .hclk(clk), .hrst(hrst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0_b), .gnt1(gnt1_b),
    .rvalid0(rvalid0_b), .rvalid1(rvalid1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .sram_scn(scn_b), .sram_wen(wen_b), .sram_a(a_b), .sram_d(d_b), .sram_q(q_b),
    .dbg_lock_state(st_b)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  logic [DW-1:0] pq_a;
  logic [DW-1:0] pq_b0, pq_b1;

  always @(posedge clk) begin
    if (!scn_a) begin
      if (!wen_a) mem_a[a_a] <= d_a;
      else        pq_a <= mem_a[a_a];
    end
  end
  assign q_a = pq_a;

  always @(posedge clk) begin
    if (!scn_b) begin
      if (!wen_b) mem_b[a_b] <= d_b;
      else        pq_b0 <= mem_b[a_b];
    end
    pq_b1 <= pq_b0;
  end
  assign q_b = pq_b1;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[5] = 32'hA5A5_A5A5; mem_b[5] = 32'hA5A5_A5A5;
    mem_a[0] = 32'hC0DE_0000; mem_b[0] = 32'hC0DE_0000;
    mem_a[1] = 32'hC0DE_0001; mem_b[1] = 32'hC0DE_0001;
    mem_a[2] = 32'hC0DE_0002; mem_b[2] = 32'hC0DE_0002;
    mem_a[3] = 32'hC0DE_0003; mem_b[3] = 32'hC0DE_0003;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  bit no_resp = 1'b0;
  // entry = {port, data, due cycle}
  logic [48:0] exp_qa[$];
  logic [48:0] exp_qb[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input bit inst_b, input logic v0, input logic v1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [48:0] e;
    logic [48:0] got;
    int qsize;
    if (v0 === 1'b1 || v1 === 1'b1) begin
      got = {v1, (v1 ? d1 : d0), cyc[15:0]};
      if (v0 === 1'b1 && v1 === 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL rvalid_both_%s: got rvalid0=1 rvalid1=1 expected at most one", inst_b ? "b" : "a");
      end
      qsize = inst_b ? exp_qb.size() : exp_qa.size();
      if (qsize == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL rd_unexpected_%s: got response %h expected none (cycle %0d)", inst_b ? "b" : "a", got, cyc);
      end else begin
        e = inst_b ? exp_qb.pop_front() : exp_qa.pop_front();
        cmp(inst_b ? "rd_resp_b" : "rd_resp_a", 64'(got), 64'(e));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(1'b0, rvalid0_a, rvalid1_a, rdata0_a, rdata1_a);
    mon(1'b1, rvalid0_b, rvalid1_b, rdata0_b, rdata1_b);
  end

  // ---------------- driver tasks ----------------
  task automatic check_pins(input logic [1:0] eg);
    logic [47:0] exp;
    exp = {2'b00, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}};
    if (eg == 2'b01)      exp = {2'b01, 1'b0, ~we0, addr0, wdata0};
    else if (eg == 2'b10) exp = {2'b10, 1'b0, ~we1, addr1, wdata1};
    cmp("gnt_pins_a", 64'({gnt1_a, gnt0_a, scn_a, wen_a, a_a, d_a}), 64'(exp));
    cmp("gnt_pins_b", 64'({gnt1_b, gnt0_b, scn_b, wen_b, a_b, d_b}), 64'(exp));
  endtask

  // One cycle: check grant and SRAM pins mid-cycle, queue the expected read return.
  task automatic step(input logic [1:0] eg, input logic [DW-1:0] erd);
    @(negedge clk);
    check_pins(eg);
    if (!no_resp && !hrst) begin
      if (eg == 2'b01 && !we0) begin
        exp_qa.push_back({1'b0, erd, 16'(cyc + LAT_A + 1)});
        exp_qb.push_back({1'b0, erd, 16'(cyc + LAT_B + 1)});
      end
      if (eg == 2'b10 && !we1) begin
        exp_qa.push_back({1'b1, erd, 16'(cyc + LAT_A + 1)});
        exp_qb.push_back({1'b1, erd, 16'(cyc + LAT_B + 1)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0);
  endtask

  task automatic check_rst();
    cmp("rst_out_a", 64'({st_a, rvalid1_a, rvalid0_a}), 64'(0));
    cmp("rst_out_b", 64'({st_b, rvalid1_b, rvalid0_b}), 64'(0));
    cmp("rst_rdata_a", {rdata1_a, rdata0_a}, 64'(0));
    cmp("rst_rdata_b", {rdata1_b, rdata0_b}, 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hrst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset holds grants low even with a request present
    req0 = 1; addr0 = 12'h005;
    step(2'b00, '0); check_rst();
    step(2'b00, '0); check_rst();

    // single read from port 0
    hrst = 0;
    step(2'b01, 32'hA5A5_A5A5);
    req0 = 0;
    idle(3);

    // port 1 write then port 0 read of the same word
    req1 = 1; we1 = 1; addr1 = 12'h123; wdata1 = 32'hDEAD_BEEF;
    step(2'b10, '0);
    req1 = 0; we1 = 0; wdata1 = '0;
    req0 = 1; addr0 = 12'h123;
    step(2'b01, 32'hDEAD_BEEF);
    req0 = 0;
    idle(3);

    // back-to-back port 1 reads
    req1 = 1;
    addr1 = 12'h000; step(2'b10, 32'hC0DE_0000);
    addr1 = 12'h001; step(2'b10, 32'hC0DE_0001);
    addr1 = 12'h002; step(2'b10, 32'hC0DE_0002);
    addr1 = 12'h003; step(2'b10, 32'hC0DE_0003);
    req1 = 0;
    idle(4);

    // plain contention alternates, starting with port 0 (port 1 was last)
    req0 = 1; addr0 = 12'h005;
    req1 = 1; addr1 = 12'h123;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(2'b01, 32'hA5A5_A5A5);
      else            step(2'b10, 32'hDEAD_BEEF);
    end
    req0 = 0; req1 = 0;
    idle(4);

    // locked port 0 write burst against a continuously requesting port 1
    req0 = 1; we0 = 1; lock0 = 1;
    req1 = 1; we1 = 0; addr1 = 12'h005;
    for (int i = 0; i < 22; i++) begin
      addr0 = 12'h300 + 12'(i);
      wdata0 = 32'h5000_0000 + 32'(i);
      if (i == 8 || i == 17) step(2'b10, 32'hA5A5_A5A5);
      else                   step(2'b01, '0);
    end
    req0 = 0; we0 = 0; lock0 = 0; wdata0 = '0; req1 = 0;
    idle(2);
    req0 = 1; addr0 = 12'h309;
    step(2'b01, 32'h5000_0009);
    req0 = 0;
    idle(3);

    // read then reset while locked: response discarded, pointer and lock cleared
    req0 = 1; lock0 = 1; addr0 = 12'h005;
    no_resp = 1;
    step(2'b01, '0);
    hrst = 1; req1 = 1; addr1 = 12'h123;
    step(2'b00, '0); check_rst();
    step(2'b00, '0); check_rst();
    hrst = 0; no_resp = 0; lock0 = 0;
    step(2'b01, 32'hA5A5_A5A5);
    req0 = 0;
    step(2'b10, 32'hDEAD_BEEF);
    req1 = 0;
    idle(6);

    cmp("drain_a", 64'(exp_qa.size()), 64'(0));
    cmp("drain_b", 64'(exp_qb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
